// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 active-low matrix keypad one column at a time,
//            debounces press and release, and encodes each accepted press
//            as a 4-bit key code with a single-cycle key_valid strobe.
//            Codes: digits map to themselves, A-D to 4'hA-4'hD,
//            '*' to 4'hE and '#' (PIN enter) to 4'hF.
// Ports    : clk        system clock (1 kHz)
//            rst        asynchronous, active-high reset
//            row_in     [3:0] keypad rows, active-low
//            col_out    [3:0] column drive, active-low, exactly one bit low
//            key_valid  one-cycle pulse for each newly accepted key
//            key_code   [3:0] code of the last accepted key (held)
// Options  : define KEYPAD_SYNC_EN to pass row_in through a two-flop
//            synchroniser (adds 2 cycles to every row decision and
//            requires SCAN_DWELL >= 3).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int MAX_CNT = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_FULL   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_CNT);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       col_idx, col_n;
  logic [1:0]       row_idx, row_n;
  logic [CNT_W-1:0] dwell_cnt, dwell_n;
  logic [CNT_W-1:0] deb_cnt, deb_n;
  logic             valid_n;
  logic [3:0]       code_n;

  logic [3:0]       rows_s;
  logic             any_low;
  logic [1:0]       low_row;
  logic             row_good;

  generate
    if (SCAN_DWELL < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("keypad_scanner: SCAN_DWELL and DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1, sync2;

  // Idle level (all rows released) so a reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
    end
  end

  assign rows_s = sync2;

  // The two-cycle lag must fit inside one column dwell, otherwise the
  // evaluated rows would belong to the previously driven column.
  generate
    if (SCAN_DWELL < 3) begin : g_dwell_check
      $error("keypad_scanner: SCAN_DWELL must be >= 3 with KEYPAD_SYNC_EN");
    end
  endgenerate
`else
  assign rows_s = row_in;
`endif

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) low_row = 2'(i);
    end
  end

  assign any_low  = ~&rows_s;
  assign row_good = any_low && (low_row == row_idx);
  assign col_out  = ~(4'b0001 << col_idx);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      row_idx   <= row_n;
      dwell_cnt <= dwell_n;
      deb_cnt   <= deb_n;
      key_valid <= valid_n;
      key_code  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col_idx;
    row_n   = row_idx;
    dwell_n = dwell_cnt;
    deb_n   = deb_cnt;
    valid_n = 1'b0;
    code_n  = key_code;

    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          if (any_low) begin
            row_n   = low_row;
            deb_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n   = col_idx + 2'd1;
            dwell_n = '0;
          end
        end else begin
          dwell_n = sat_inc(dwell_cnt);
        end
      end

      DEBOUNCE: begin
        // Acceptance is decided one cycle after the last good sample so the
        // strobe lands DEBOUNCE_CYCLES+1 cycles after the first one.
        if (deb_cnt == DEB_FULL) begin
          code_n  = map_key(row_idx, col_idx);
          valid_n = 1'b1;
          deb_n   = '0;
          state_n = WAIT_RELEASE;
        end else if (!row_good) begin
          dwell_n = '0;
          state_n = SCAN;
        end else begin
          deb_n = sat_inc(deb_cnt);
        end
      end

      WAIT_RELEASE: begin
        if (any_low) begin
          deb_n = '0;
        end else if (deb_cnt == DEB_LAST) begin
          col_n   = col_idx + 2'd1;
          dwell_n = '0;
          deb_n   = '0;
          state_n = SCAN;
        end else begin
          deb_n = sat_inc(deb_cnt);
        end
      end

      default: begin
        state_n = SCAN;
        dwell_n = '0;
        deb_n   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner. A keypad model turns a
//            16-bit "pressed" map plus the driven column into row_in. A
//            cycle-level reference model, written in terms of elapsed cycle
//            counts rather than counters, predicts col_out/key_valid/key_code
//            every cycle; directed scenarios add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DWELL = 4;
  localparam int DEB        = 20;
`ifdef KEYPAD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] pressed = '0;   // bit r*4+c set = key at (row r, col c) closed

  int tests      = 0;
  int fails      = 0;
  int cyc        = 0;
  int pulse_cnt  = 0;
  int last_pulse = -1;

  keypad_scanner #(
    .SCAN_DWELL     (SCAN_DWELL),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its row low when its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && pressed[r*4+c]) row_in[r] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  function automatic logic [3:0] rows_for(input int col, input logic [15:0] keys);
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = ~keys[r*4+col];
    return v;
  endfunction

  function automatic int lowest_zero(input logic [3:0] v);
    for (int r = 0; r < 4; r++) if (!v[r]) return r;
    return 4;
  endfunction

  int         m_phase;   // 0 scanning, 1 debouncing, 2 awaiting release
  int         m_col, m_row, m_t0, m_tlow, m_cyc;
  logic       m_kv;
  logic [3:0] m_kc, m_h1, m_h2;

  always @(posedge clk or posedge rst) begin
    logic [3:0] cur, rs;
    if (rst) begin
      m_phase = 0; m_col = 0; m_row = 0; m_t0 = 0; m_tlow = 0; m_cyc = 0;
      m_kv = 1'b0; m_kc = 4'h0; m_h1 = 4'hF; m_h2 = 4'hF;
    end else begin
      cur  = rows_for(m_col, pressed);
      rs   = (SYNC_LAT == 2) ? m_h2 : cur;
      m_h2 = m_h1;
      m_h1 = cur;
      m_kv = 1'b0;
      case (m_phase)
        0: if (m_cyc - m_t0 == SCAN_DWELL - 1) begin
             if (rs != 4'hF) begin
               m_row = lowest_zero(rs); m_phase = 1; m_t0 = m_cyc + 1;
             end else begin
               m_col = (m_col + 1) % 4; m_t0 = m_cyc + 1;
             end
           end
        1: if (m_cyc - m_t0 == DEB) begin
             m_kv = 1'b1; m_kc = keymap[m_row*4 + m_col]; m_phase = 2; m_tlow = m_cyc;
           end else if (lowest_zero(rs) != m_row) begin
             m_phase = 0; m_t0 = m_cyc + 1;
           end
        default: if (rs != 4'hF) m_tlow = m_cyc;
                 else if (m_cyc - m_tlow == DEB) begin
                   m_col = (m_col + 1) % 4; m_phase = 0; m_t0 = m_cyc + 1;
                 end
      endcase
      m_cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [3:0] ec;
    #3;
    ec = 4'hF;
    ec[m_col[1:0]] = 1'b0;
    check("col_out", 32'(col_out), 32'(ec));
    check("key_valid", 32'(key_valid), 32'(m_kv));
    check("key_code", 32'(key_code), 32'(m_kc));
    if (rst) begin
      pulse_cnt  = 0;
      last_pulse = -1;
    end else if (key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse = cyc;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk);
    rst     = 1'b1;
    pressed = keys;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  initial begin
    logic [3:0] col_seq [5];
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Idle scan after reset
    do_reset(16'h0000);
    check("rst col_out", 32'(col_out), 32'h0000000E);
    check("rst key_valid", 32'(key_valid), 32'h0);
    check("rst key_code", 32'(key_code), 32'h0);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(4*k);
      check("idle col seq", 32'(col_out), 32'(col_seq[k]));
    end

    // '5' held then released: DEBOUNCE entered at cycle 8, pulse at 29
    do_reset(16'h0020);
    wait_cyc(40);
    pressed = 16'h0000;
    wait_cyc(59 + SYNC_LAT);
    check("5 col before resume", 32'(col_out), 32'h0000000D);
    wait_cyc(60 + SYNC_LAT);
    check("5 col after resume", 32'(col_out), 32'h0000000B);
    wait_cyc(80);
    check("5 pulse count", 32'(pulse_cnt), 32'd1);
    check("5 pulse cycle", 32'(last_pulse), 32'd29);
    check("5 key_code", 32'(key_code), 32'h5);

    // '#' with bounce early in debounce: restart, pulse at 55 (+sync lag)
    do_reset(16'h4000);
    for (int k = 13; k <= 18; k++) begin
      wait_cyc(k);
      pressed = (k % 2 == 1) ? 16'h0000 : 16'h4000;
    end
    wait_cyc(150);
    check("# pulse count", 32'(pulse_cnt), 32'd1);
    check("# pulse cycle", 32'(last_pulse), 32'(55 + SYNC_LAT));
    check("# key_code", 32'(key_code), 32'hF);

    // '1' and '4' together, held 200+ cycles: one pulse, row 0 wins
    do_reset(16'h0011);
    wait_cyc(225);
    check("1+4 pulse count", 32'(pulse_cnt), 32'd1);
    check("1+4 pulse cycle", 32'(last_pulse), 32'd25);
    check("1+4 key_code", 32'(key_code), 32'h1);

    // 'D' with reset at debounce cycle 10 (DEBOUNCE entered at cycle 16)
    do_reset(16'h8000);
    wait_cyc(26);
    check("D no early pulse", 32'(pulse_cnt), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("D async rst col_out", 32'(col_out), 32'h0000000E);
    check("D async rst key_valid", 32'(key_valid), 32'h0);
    check("D async rst key_code", 32'(key_code), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_cyc(60);
    check("D pulse count", 32'(pulse_cnt), 32'd1);
    check("D pulse cycle", 32'(last_pulse), 32'd37);
    check("D key_code", 32'(key_code), 32'hD);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
